// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: register offsets,
// FSM state encoding, well-known source indices and a mask helper.
// Imported by irq_controller and irq_priority_encoder.
package irq_pkg;

   // Maximum number of sources the register map can hold.
   localparam int MAX_IRQ = 16;

   // Register offsets from the block base address.
   localparam logic [2:0] OFF_PRIO0    = 3'd0;
   localparam logic [2:0] OFF_PRIO1    = 3'd1;
   localparam logic [2:0] OFF_PRIO2    = 3'd2;
   localparam logic [2:0] OFF_PRIO3    = 3'd3;
   localparam logic [2:0] OFF_ENABLE_L = 3'd4;
   localparam logic [2:0] OFF_ENABLE_H = 3'd5;
   localparam logic [2:0] OFF_ACTIVE_L = 3'd6;
   localparam logic [2:0] OFF_ACTIVE_H = 3'd7;

   // Request handshake states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_GAP  = 2'd2
   } irq_state_t;

   // Source wiring on the system bus.
   localparam int SRC_TIMER_L_UF = 0;
   localparam int SRC_TIMER_H_UF = 1;
   localparam int SRC_TIMER_CMP  = 2;
   localparam int SRC_RTC        = 3;
   localparam int SRC_KEY0       = 4;
   localparam int SRC_KEY1       = 5;
   localparam int SRC_KEY2       = 6;
   localparam int SRC_KEY3       = 7;

   // Widen a per-source mask into a per-priority-field mask (2 bits each).
   function automatic logic [31:0] spread2(input logic [15:0] m);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < MAX_IRQ; i++) begin
         r[2*i +: 2] = {m[i], m[i]};
      end
      return r;
   endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// Picks the highest-priority candidate source; ties go to the lowest index.
// Purely combinational, zero latency.
// No flow control; output valid whenever any candidate bit is set.
module irq_priority_encoder
   import irq_pkg::*;
(
   input  logic [15:0] cand,
   input  logic [31:0] prio,
   output logic [3:0]  win_idx,
   output logic [1:0]  win_level,
   output logic        win_valid
);

   logic [1:0] best;

   // Scan upward; a strictly greater level is needed to replace the current
   // best, so the lowest index keeps a tie.
   always_comb begin
      best      = 2'd0;
      win_idx   = 4'd0;
      win_valid = 1'b0;
      for (int i = 0; i < MAX_IRQ; i++) begin
         if (cand[i] && (prio[2*i +: 2] > best)) begin
            best      = prio[2*i +: 2];
            win_idx   = 4'(i);
            win_valid = 1'b1;
         end
      end
      win_level = best;
   end

endmodule

// File: rtl/irq_controller.sv
// Latches peripheral IRQ pulses, arbitrates by enable/priority/mask, and
// posts one vector at a time to the CPU. Pulse to irq_req: 2 cycles.
// CPU backpressure via req/ack; a posted request is held until ack or withdrawal.
module irq_controller
   import irq_pkg::*;
#(
   parameter int          NUM_IRQ     = 16,
   parameter logic [4:0]  VECTOR_BASE = 5'h03,
   parameter logic [23:0] REG_BASE    = 24'h2020
)(
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic               bus_write,
   input  logic               bus_read,
   input  logic [23:0]        bus_address_in,
   input  logic [7:0]         bus_data_in,
   output logic [7:0]         bus_data_out,
   input  logic [1:0]         cpu_mask_level,
   output logic               irq_req,
   output logic [4:0]         irq_vector,
   output logic [1:0]         irq_level,
   input  logic               cpu_ack
);

   // Storage is sized for the full map; bits of absent sources are forced 0.
   localparam logic [15:0] SRC_MASK  = 16'((32'd1 << NUM_IRQ) - 32'd1);
   localparam logic [31:0] PRIO_MASK = spread2(SRC_MASK);

   logic [31:0] prio;
   logic [15:0] enable;
   logic [15:0] active;
   logic [15:0] irq_ext;
   logic [15:0] cand;
   logic [15:0] bus_clr;
   logic [15:0] ack_clr;
   logic [23:0] off;
   logic        in_win;
   logic        wr_hit;
   logic [3:0]  enc_idx;
   logic [1:0]  enc_level;
   logic        enc_valid;
   logic [3:0]  win_idx_q;
   irq_state_t  state;

   assign irq_ext = 16'(irq_in);
   assign off     = bus_address_in - REG_BASE;
   assign in_win  = (bus_address_in >= REG_BASE) && (off < 24'd8);
   assign wr_hit  = bus_write && in_win;

   // Candidate: pending, enabled, non-zero priority above the CPU mask.
   always_comb begin
      cand = '0;
      for (int i = 0; i < MAX_IRQ; i++) begin
         cand[i] = active[i] && enable[i] && (prio[2*i +: 2] != 2'd0)
                   && (prio[2*i +: 2] > cpu_mask_level);
      end
   end

   irq_priority_encoder u_enc (
      .cand      (cand),
      .prio      (prio),
      .win_idx   (enc_idx),
      .win_level (enc_level),
      .win_valid (enc_valid)
   );

   // Read mux, qualified by the read strobe; unmapped addresses return 0.
   always_comb begin
      bus_data_out = 8'h00;
      if (bus_read && in_win) begin
         case (off[2:0])
            OFF_PRIO0:    bus_data_out = prio[7:0];
            OFF_PRIO1:    bus_data_out = prio[15:8];
            OFF_PRIO2:    bus_data_out = prio[23:16];
            OFF_PRIO3:    bus_data_out = prio[31:24];
            OFF_ENABLE_L: bus_data_out = enable[7:0];
            OFF_ENABLE_H: bus_data_out = enable[15:8];
            OFF_ACTIVE_L: bus_data_out = active[7:0];
            default:      bus_data_out = active[15:8];
         endcase
      end
   end

   // Write-one-to-clear masks from the bus and from a CPU acknowledge.
   always_comb begin
      bus_clr = '0;
      ack_clr = '0;
      if (wr_hit && off[2:0] == OFF_ACTIVE_L) bus_clr = {8'h00, bus_data_in};
      if (wr_hit && off[2:0] == OFF_ACTIVE_H) bus_clr = {bus_data_in, 8'h00};
      if (state == ST_REQ && cpu_ack)         ack_clr = 16'h0001 << win_idx_q;
   end

   // Priority and enable registers, written in any FSM state.
   always_ff @(posedge clk) begin
      if (reset) begin
         prio   <= '0;
         enable <= '0;
      end else if (wr_hit) begin
         case (off[2:0])
            OFF_PRIO0:    prio[7:0]    <= bus_data_in & PRIO_MASK[7:0];
            OFF_PRIO1:    prio[15:8]   <= bus_data_in & PRIO_MASK[15:8];
            OFF_PRIO2:    prio[23:16]  <= bus_data_in & PRIO_MASK[23:16];
            OFF_PRIO3:    prio[31:24]  <= bus_data_in & PRIO_MASK[31:24];
            OFF_ENABLE_L: enable[7:0]  <= bus_data_in & SRC_MASK[7:0];
            OFF_ENABLE_H: enable[15:8] <= bus_data_in & SRC_MASK[15:8];
            default: ;
         endcase
      end
   end

   // Pending flags: a new pulse wins over any clear of the same bit.
   always_ff @(posedge clk) begin
      if (reset) active <= '0;
      else       active <= ((active & ~bus_clr & ~ack_clr) | irq_ext) & SRC_MASK;
   end

   // Request handshake; vector and level only change while irq_req is low.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         irq_req    <= 1'b0;
         irq_vector <= 5'd0;
         irq_level  <= 2'd0;
         win_idx_q  <= 4'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (enc_valid) begin
                  win_idx_q  <= enc_idx;
                  irq_vector <= VECTOR_BASE + {1'b0, enc_idx};
                  irq_level  <= enc_level;
                  irq_req    <= 1'b1;
                  state      <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (cpu_ack) begin
                  irq_req <= 1'b0;
                  state   <= ST_GAP;
               end else if (!cand[win_idx_q]) begin
                  irq_req <= 1'b0;
                  state   <= ST_IDLE;
               end
            end
            default: begin
               irq_req <= 1'b0;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
